// File: rtl/corner_collector.sv
// ---------------------------------------------------------------------------
// corner_collector
//
// Collects corner detections from a pixel stream into a first-word-fall-
// through FIFO. Each interior corner (x != 0, y != 0) becomes an entry
// {1'b0, y[9:0], x[9:0]}. On frame end a marker {1'b1, count[19:0]} is
// written on the following edge. The marker carries the number of corners
// written since the previous marker. One FIFO slot is always held back for
// the marker, so corners only enter while fill_level <= DEPTH-2.
//
// Ports
//   clk          single clock, rising edge
//   rst          synchronous active-high reset
//   ce           pixel strobe; corner_in and coordinates valid when high
//   corner_in    corner decision for the current pixel
//   x_coord_in   column of the current pixel
//   y_coord_in   row of the current pixel
//   out_valid    head entry available (fill_level != 0)
//   out_ready    consumer accepts the head entry
//   out_data     head entry (bit 20 = marker flag)
//   fill_level   current FIFO occupancy
//   overflow     sticky: at least one corner dropped
//   marker_lost  sticky: at least one frame marker dropped
// ---------------------------------------------------------------------------
module corner_collector #(
  parameter int COL_NUM = 640,
  parameter int ROW_NUM = 480,
  parameter int DEPTH   = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       ce,
  input  logic                       corner_in,
  input  logic [9:0]                 x_coord_in,
  input  logic [9:0]                 y_coord_in,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [20:0]                out_data,
  output logic [$clog2(DEPTH):0]     fill_level,
  output logic                       overflow,
  output logic                       marker_lost
);

  localparam int AW = $clog2(DEPTH);

  localparam logic [AW:0] LVL_FULL   = (AW+1)'(DEPTH);
  localparam logic [AW:0] LVL_CORNER = (AW+1)'(DEPTH - 2);
  localparam logic [9:0]  X_LAST     = 10'(COL_NUM - 1);
  localparam logic [9:0]  Y_LAST     = 10'(ROW_NUM - 1);

  logic [20:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   level;
  logic [19:0]   count;
  logic          pending;

  logic          pop;
  logic          corner_ev;
  logic          frame_end;
  logic          mk_wr;
  logic          mk_drop;
  logic          cn_wr;
  logic          cn_drop;
  logic [AW:0]   lvl_pop;
  logic [AW:0]   lvl_mk;
  logic [AW:0]   level_n;
  logic [AW-1:0] cn_addr;
  logic [19:0]   count_n;

  assign out_valid  = (level != '0);
  assign fill_level = level;
  // Gated so the output reads zero while empty, including straight after reset.
  assign out_data   = out_valid ? mem[rd_ptr] : '0;

  always_comb begin
    pop       = out_valid && out_ready;
    corner_ev = ce && corner_in && (x_coord_in != '0) && (y_coord_in != '0);
    frame_end = ce && (x_coord_in == X_LAST) && (y_coord_in == Y_LAST);

    // A pop in this cycle frees its slot before any push is judged.
    lvl_pop = level - (AW+1)'(pop);

    // The pending marker belongs to the finished frame, so it goes in ahead
    // of any corner arriving in the same cycle and is judged first.
    mk_wr   = pending && (lvl_pop != LVL_FULL);
    mk_drop = pending && !mk_wr;
    lvl_mk  = lvl_pop + (AW+1)'(mk_wr);

    cn_wr   = corner_ev && (lvl_mk <= LVL_CORNER);
    cn_drop = corner_ev && !cn_wr;
    cn_addr = wr_ptr + AW'(mk_wr);

    level_n = lvl_mk + (AW+1)'(cn_wr);

    // The marker edge restarts the count; a corner on that same edge already
    // belongs to the new frame.
    count_n = (pending ? 20'd0 : count) + 20'(cn_wr);
  end

  // Control state
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      level       <= '0;
      count       <= '0;
      pending     <= 1'b0;
      overflow    <= 1'b0;
      marker_lost <= 1'b0;
    end else begin
      wr_ptr  <= wr_ptr + AW'(mk_wr) + AW'(cn_wr);
      rd_ptr  <= rd_ptr + AW'(pop);
      level   <= level_n;
      count   <= count_n;
      pending <= frame_end;
      if (cn_drop) overflow    <= 1'b1;
      if (mk_drop) marker_lost <= 1'b1;
    end
  end

  // Storage; not reset, the level/pointers define what is valid
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (mk_wr) mem[wr_ptr]  <= {1'b1, count};
      if (cn_wr) mem[cn_addr] <= {1'b0, y_coord_in, x_coord_in};
    end
  end

endmodule

// File: tb/tb_corner_collector.sv
module tb_corner_collector;

  logic        clk = 1'b0;
  logic        rst;
  logic        ce;
  logic        corner_in;
  logic [9:0]  x_coord_in;
  logic [9:0]  y_coord_in;
  logic        out_valid;
  logic        out_ready;
  logic [20:0] out_data;
  logic [6:0]  fill_level;
  logic        overflow;
  logic        marker_lost;

  int total  = 0;
  int passed = 0;

  corner_collector #(.COL_NUM(640), .ROW_NUM(480), .DEPTH(64)) dut (
    .clk         (clk),
    .rst         (rst),
    .ce          (ce),
    .corner_in   (corner_in),
    .x_coord_in  (x_coord_in),
    .y_coord_in  (y_coord_in),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .fill_level  (fill_level),
    .overflow    (overflow),
    .marker_lost (marker_lost)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  // Apply one set of inputs across one rising edge, then settle 1 time unit.
  task automatic step(input logic c, input logic k, input int x, input int y, input logic rdy);
    ce         = c;
    corner_in  = k;
    x_coord_in = 10'(x);
    y_coord_in = 10'(y);
    out_ready  = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic rdy);
    step(1'b0, 1'b0, 0, 0, rdy);
  endtask

  function automatic logic [31:0] cw(input int x, input int y);
    return {11'd0, 1'b0, 10'(y), 10'(x)};
  endfunction

  initial begin
    rst = 1'b1;
    ce = 1'b0; corner_in = 1'b0; x_coord_in = '0; y_coord_in = '0; out_ready = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;

    chk("reset_fill",        32'(fill_level),  32'd0);
    chk("reset_valid",       32'(out_valid),   32'd0);
    chk("reset_data",        32'(out_data),    32'd0);
    chk("reset_overflow",    32'(overflow),    32'd0);
    chk("reset_marker_lost", 32'(marker_lost), 32'd0);

    // Two corners with a ready consumer; each visible one cycle after write
    step(1'b1, 1'b1, 5, 3, 1'b1);
    chk("c1_valid", 32'(out_valid), 32'd1);
    chk("c1_data",  32'(out_data),  32'h00C05);
    step(1'b1, 1'b1, 7, 3, 1'b1);
    chk("c2_data",  32'(out_data),  32'h00C07);
    chk("c2_fill",  32'(fill_level), 32'd1);
    idle(1'b1);
    chk("c2_drained", 32'(out_valid), 32'd0);

    // ce=0 ignores corners and frame end; ready on empty FIFO does nothing
    step(1'b0, 1'b1, 9, 9, 1'b1);
    step(1'b0, 1'b0, 639, 479, 1'b1);
    idle(1'b1);
    chk("ce0_fill", 32'(fill_level), 32'd0);

    // Frame end: marker with count 2 on the next edge
    step(1'b1, 1'b0, 639, 479, 1'b0);
    chk("fe1_not_yet", 32'(fill_level), 32'd0);
    idle(1'b0);
    chk("fe1_fill",   32'(fill_level), 32'd1);
    chk("fe1_marker", 32'(out_data),   32'h100002);
    idle(1'b1);

    // Border corners discarded; only (3,3) stored and counted
    step(1'b1, 1'b1, 0, 4, 1'b0);
    step(1'b1, 1'b1, 4, 0, 1'b0);
    step(1'b1, 1'b1, 3, 3, 1'b0);
    chk("border_fill", 32'(fill_level), 32'd1);
    chk("border_data", 32'(out_data),   32'h00C03);
    step(1'b1, 1'b0, 639, 479, 1'b0);
    idle(1'b0);
    chk("border_fill2", 32'(fill_level), 32'd2);
    idle(1'b1);
    chk("border_marker", 32'(out_data), 32'h100001);
    idle(1'b1);

    // Corner on the frame-end pixel: corner then marker counting it
    step(1'b1, 1'b1, 639, 479, 1'b0);
    chk("last_px_fill", 32'(fill_level), 32'd1);
    chk("last_px_data", 32'(out_data),   32'h77E7F);
    idle(1'b0);
    chk("last_px_fill2", 32'(fill_level), 32'd2);
    idle(1'b1);
    chk("last_px_marker", 32'(out_data), 32'h100001);
    idle(1'b1);
    chk("last_px_empty", 32'(fill_level), 32'd0);

    // Reset with 10 entries and a pending marker
    for (int i = 1; i <= 10; i++) step(1'b1, 1'b1, i, 1, 1'b0);
    chk("pre_rst_fill", 32'(fill_level), 32'd10);
    step(1'b1, 1'b0, 639, 479, 1'b0);
    rst = 1'b1;
    idle(1'b1);
    rst = 1'b0;
    chk("rst_valid", 32'(out_valid),  32'd0);
    chk("rst_fill",  32'(fill_level), 32'd0);
    chk("rst_data",  32'(out_data),   32'd0);
    idle(1'b0);
    idle(1'b0);
    chk("rst_no_marker", 32'(fill_level), 32'd0);

    // 70 corners into a stalled FIFO: 63 stored, rest dropped
    for (int i = 1; i <= 70; i++) step(1'b1, 1'b1, i, 5, 1'b0);
    chk("ovf_fill", 32'(fill_level), 32'd63);
    chk("ovf_flag", 32'(overflow),   32'd1);
    chk("ovf_mlost_clear", 32'(marker_lost), 32'd0);
    chk("ovf_head", 32'(out_data), cw(1, 5));
    step(1'b1, 1'b0, 639, 479, 1'b0);
    idle(1'b0);
    chk("ovf_fill_full", 32'(fill_level), 32'd64);
    // Second frame end with a completely full FIFO: marker dropped
    step(1'b1, 1'b0, 639, 479, 1'b0);
    idle(1'b0);
    chk("mlost_flag", 32'(marker_lost), 32'd1);
    chk("mlost_fill", 32'(fill_level),  32'd64);
    for (int i = 1; i <= 63; i++) begin
      chk("ovf_order", 32'(out_data), cw(i, 5));
      idle(1'b1);
    end
    chk("ovf_marker", 32'(out_data),   32'h10003F);
    chk("ovf_fill1",  32'(fill_level), 32'd1);
    idle(1'b1);
    chk("ovf_empty", 32'(fill_level), 32'd0);
    chk("ovf_sticky", 32'(overflow), 32'd1);

    // Corner-full FIFO (DEPTH-1): pop and corner together, corner fits
    for (int i = 1; i <= 63; i++) step(1'b1, 1'b1, i, 7, 1'b0);
    chk("pp_fill_pre", 32'(fill_level), 32'd63);
    step(1'b1, 1'b1, 9, 9, 1'b1);
    chk("pp_fill", 32'(fill_level), 32'd63);
    for (int i = 2; i <= 63; i++) begin
      chk("pp_order", 32'(out_data), cw(i, 7));
      idle(1'b1);
    end
    chk("pp_last", 32'(out_data), 32'h02409);
    idle(1'b1);
    chk("pp_empty", 32'(out_valid), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/corner_collector.md
CORNER_COLLECTOR -- requirements
Module: corner_collector

Interface
REQ-001 SHALL have parameter COL_NUM, default 640, pixels per row.
REQ-002 SHALL have parameter ROW_NUM, default 480, rows per frame.
REQ-003 SHALL have parameter DEPTH, default 64, FIFO entries; power of two, >= 4.
REQ-004 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-006 SHALL have port ce  input  1  pixel strobe; corner_in and coordinates valid only when high.
REQ-007 SHALL have port corner_in  input  1  NMS-stage corner decision for the current pixel.
REQ-008 SHALL have port x_coord_in  input  10  column of the current pixel.
REQ-009 SHALL have port y_coord_in  input  10  row of the current pixel.
REQ-010 SHALL have port out_valid  output  1  head FIFO entry available.
REQ-011 SHALL have port out_ready  input  1  consumer accepts the head entry.
REQ-012 SHALL have port out_data  output  21  head entry: bit20 marker flag; corner = {0, y[9:0], x[9:0]}; marker = {1, count[19:0]}.
REQ-013 SHALL have port fill_level  output  log2(DEPTH)+1  current FIFO occupancy.
REQ-014 SHALL have port overflow  output  1  sticky flag: at least one corner dropped.
REQ-015 SHALL have port marker_lost  output  1  sticky flag: at least one frame marker dropped.

Function
REQ-016 SHALL define a corner event as ce=1, corner_in=1, x_coord_in!=0, y_coord_in!=0; border corners (row 0 or column 0) SHALL be discarded silently, without counting or flagging.
REQ-017 SHALL define frame end as ce=1 with x_coord_in=COL_NUM-1 and y_coord_in=ROW_NUM-1.
REQ-018 SHALL write a corner event into the FIFO in the same edge when fill_level <= DEPTH-2, one slot always being reserved for the marker.
REQ-019 SHALL drop a corner event when fill_level >= DEPTH-1, set overflow, and exclude it from the frame count.
REQ-020 SHALL keep a 20-bit frame counter incremented once per written corner; drops SHALL NOT increment it.
REQ-021 SHALL set a marker-pending register on frame end and write the marker {1, count} on the following clock edge; a corner event in the frame-end cycle SHALL be written in that cycle and included in count.
REQ-022 SHALL clear the frame counter in the same edge the marker is written or dropped.
REQ-023 SHALL drop the marker and set marker_lost when the FIFO is full (fill_level = DEPTH) at the marker-write edge.
REQ-024 SHALL drive out_valid high exactly when fill_level != 0; out_data SHALL show the oldest entry (first-word-fall-through).
REQ-025 SHALL pop the head on a clock edge where out_valid=1 and out_ready=1; out_data SHALL remain stable while out_valid=1 and out_ready=0.
REQ-026 SHALL leave fill_level unchanged on simultaneous push and pop; pops SHALL precede pushes for the full check, so a pop frees a slot in the same cycle.
REQ-027 SHALL present a corner written at edge N with out_valid=1 after edge N when the FIFO was empty; latency 1 cycle.
REQ-028 SHALL wrap read and write pointers modulo DEPTH; ordering SHALL be strict FIFO across wrap.
REQ-029 SHALL ignore corner_in, coordinates and frame end when ce=0; the pending marker SHALL still be written regardless of ce.
REQ-030 SHALL NOT accept out_ready when out_valid=0 (no pointer or level change).

Reset
REQ-031 SHALL on rst=1 at an edge: empty the FIFO, set fill_level=0, out_valid=0, out_data=0, overflow=0, marker_lost=0, frame counter=0, marker-pending=0.
REQ-032 SHALL on reset mid-frame discard stored entries and any pending marker; rst has priority over all push/pop activity in the same cycle.
REQ-033 SHALL clear overflow and marker_lost only by reset.

Verification
REQ-034 SHALL cover: corners at (5,3),(7,3), out_ready=1 -> out_data 0x00C05 then 0x00C07, each out_valid one cycle after write.
REQ-035 SHALL cover: corners at (0,4),(4,0),(3,3) -> only 0x00C03 stored; frame-end marker = 0x100001.
REQ-036 SHALL cover: out_ready=0, DEPTH=64, 70 corners -> 63 stored, overflow=1, marker 0x10003F written at entry 64, fill_level=64.
REQ-037 SHALL cover: corner at (639,479) -> corner entry then marker with count including it, on consecutive edges.
REQ-038 SHALL cover: full FIFO, simultaneous pop and corner -> corner written, fill_level stays DEPTH-1 (the corner fits after the pop).
REQ-039 SHALL cover: rst pulse with 10 entries stored and marker pending -> out_valid=0, fill_level=0 next cycle, no marker emitted.
